// File: rtl/phivers_inject_arb.sv
// rtl/phivers_inject_arb.sv - round-robin multi-channel Hermes packet injector
module phivers_inject_arb #(
  parameter int N_CH      = 2,
  parameter int FLIT_SIZE = 32,
  parameter int SIZE_W    = 16,
  localparam int GW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [N_CH-1:0]           req_i,
  input  logic [N_CH*16-1:0]        target_i,
  input  logic [N_CH*SIZE_W-1:0]    size_i,
  output logic [N_CH-1:0]           ack_o,
  input  logic [N_CH*FLIT_SIZE-1:0] data_i,
  input  logic [N_CH-1:0]           data_valid_i,
  output logic [N_CH-1:0]           data_ready_o,
  output logic                      tx_o,
  output logic [FLIT_SIZE-1:0]      data_o,
  input  logic                      credit_i,
  output logic                      busy_o,
  output logic [GW-1:0]             grant_o,
  output logic [15:0]               pkt_count_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HEADER  = 2'd1;
  localparam logic [1:0] S_SIZE    = 2'd2;
  localparam logic [1:0] S_PAYLOAD = 2'd3;

  localparam int CW = GW + 1;
  localparam logic [N_CH-1:0] ACK_ONE = N_CH'(1);

  logic [1:0]           state_q;
  logic [GW-1:0]        rr_ptr_q;
  logic [GW-1:0]        grant_q;
  logic [15:0]          target_q;
  logic [SIZE_W-1:0]    size_q;
  logic [SIZE_W-1:0]    remaining_q;
  logic [N_CH-1:0]      ack_q;
  logic [15:0]          pkt_count_q;

  logic [15:0]          target_arr [N_CH];
  logic [SIZE_W-1:0]    size_arr   [N_CH];
  logic [FLIT_SIZE-1:0] data_arr   [N_CH];

  logic                 req_found;
  logic [GW-1:0]        winner;
  logic [GW-1:0]        rr_next;
  logic [CW-1:0]        cand;
  logic [CW-1:0]        nxt;
  logic                 cur_valid;
  logic [FLIT_SIZE-1:0] cur_data;

  for (genvar g = 0; g < N_CH; g++) begin : g_unpack
    assign target_arr[g] = target_i[g*16 +: 16];
    assign size_arr[g]   = size_i[g*SIZE_W +: SIZE_W];
    assign data_arr[g]   = data_i[g*FLIT_SIZE +: FLIT_SIZE];
  end

  assign cur_valid   = data_valid_i[grant_q];
  assign cur_data    = data_arr[grant_q];
  assign ack_o       = ack_q;
  assign busy_o      = (state_q != S_IDLE);
  assign grant_o     = grant_q;
  assign pkt_count_o = pkt_count_q;

  // First requester at or above the rr pointer, wrapping; also the pointer that follows it
  always_comb begin
    req_found = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = {1'b0, rr_ptr_q} + CW'(i);
      if (cand >= CW'(N_CH)) cand = cand - CW'(N_CH);
      if (!req_found && req_i[cand[GW-1:0]]) begin
        req_found = 1'b1;
        winner    = cand[GW-1:0];
      end
    end
    nxt = {1'b0, winner} + CW'(1);
    if (nxt >= CW'(N_CH)) nxt = '0;
    rr_next = nxt[GW-1:0];
  end

  // Packet sequencer: grant, header, size, then payload countdown
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      target_q    <= '0;
      size_q      <= '0;
      remaining_q <= '0;
      ack_q       <= '0;
      pkt_count_q <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (req_found) begin
            grant_q  <= winner;
            target_q <= target_arr[winner];
            size_q   <= size_arr[winner];
            ack_q    <= ACK_ONE << winner;
            rr_ptr_q <= rr_next;
            state_q  <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (credit_i) state_q <= S_SIZE;
        end
        S_SIZE: begin
          if (credit_i) begin
            if (size_q == '0) begin
              state_q     <= S_IDLE;
              pkt_count_q <= pkt_count_q + 16'd1;
            end else begin
              remaining_q <= size_q;
              state_q     <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (cur_valid && credit_i) begin
            remaining_q <= remaining_q - SIZE_W'(1);
            if (remaining_q == SIZE_W'(1)) begin
              state_q     <= S_IDLE;
              pkt_count_q <= pkt_count_q + 16'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Link mux: registered header/size words, payload passed straight through from the owner
  always_comb begin
    tx_o         = 1'b0;
    data_o       = '0;
    data_ready_o = '0;
    case (state_q)
      S_HEADER: begin
        tx_o   = 1'b1;
        data_o = FLIT_SIZE'(target_q);
      end
      S_SIZE: begin
        tx_o   = 1'b1;
        data_o = FLIT_SIZE'(size_q);
      end
      S_PAYLOAD: begin
        tx_o                  = cur_valid;
        data_o                = cur_data;
        data_ready_o[grant_q] = cur_valid && credit_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_phivers_inject_arb.sv
// tb/tb_phivers_inject_arb.sv - scoreboard and vector-table bench for phivers_inject_arb
module tb_phivers_inject_arb;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [1:0]  req_i;
  logic [31:0] target_i;
  logic [31:0] size_i;
  logic [1:0]  ack_o;
  logic [63:0] data_i;
  logic [1:0]  data_valid_i;
  logic [1:0]  data_ready_o;
  logic        tx_o;
  logic [31:0] data_o;
  logic        credit_i;
  logic        busy_o;
  logic [0:0]  grant_o;
  logic [15:0] pkt_count_o;

  phivers_inject_arb #(.N_CH(2), .FLIT_SIZE(32), .SIZE_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .target_i(target_i), .size_i(size_i),
    .ack_o(ack_o), .data_i(data_i), .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
    .tx_o(tx_o), .data_o(data_o), .credit_i(credit_i), .busy_o(busy_o),
    .grant_o(grant_o), .pkt_count_o(pkt_count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] target;
    logic [15:0] size;
    logic [31:0] base;
  } pkt_t;

  typedef struct {
    int          ch;
    logic [15:0] target;
    logic [15:0] size;
    logic [31:0] base;
    bit          bub;
    int          exp_xfers;
    int          exp_rdy;
    int          exp_pkt;
  } vec_t;

  pkt_t        pend_q [2][$];
  logic [31:0] src_q  [2][$];
  logic [31:0] sb_q   [$];
  int          grant_hist [$];

  int   checks = 0;
  int   errors = 0;
  int   xfer_cnt = 0;
  int   rdy_cnt [2] = '{0, 0};
  int   ack_cnt [2] = '{0, 0};
  bit   bubbles = 1'b0;
  int   cyc = 0;
  pkt_t mon_p;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input int c, input logic [15:0] t, input logic [15:0] s, input logic [31:0] b);
    pkt_t p;
    p.target = t;
    p.size   = s;
    p.base   = b;
    pend_q[c].push_back(p);
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(pend_q[0].size() == 0 && pend_q[1].size() == 0 && sb_q.size() == 0 && !busy_o) && n < 3000);
    if (n >= 3000) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_xfer(input string nm, input int target_cnt);
    int n;
    n = 0;
    while (xfer_cnt < target_cnt && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk({nm, "_timeout"}, 32'd0, 32'd1);
  endtask

  // Source/request driver: presents queue heads shortly after each rising edge
  initial begin
    req_i = '0; target_i = '0; size_i = '0; data_i = '0; data_valid_i = '0;
    forever begin
      @(posedge clk); #2;
      cyc++;
      for (int c = 0; c < 2; c++) begin
        req_i[c] = (pend_q[c].size() > 0);
        if (pend_q[c].size() > 0) begin
          target_i[c*16 +: 16] = pend_q[c][0].target;
          size_i[c*16 +: 16]   = pend_q[c][0].size;
        end
        data_valid_i[c]      = (src_q[c].size() > 0) && !(bubbles && cyc[0]);
        data_i[c*32 +: 32]   = (src_q[c].size() > 0) ? src_q[c][0] : 32'h0;
      end
    end
  end

  // Monitor: on ack expand the packet into expected flits, then check every link flit
  always @(negedge clk) begin
    if (!rst_i) begin
      chk("ack_onehot", 32'($countones(ack_o) <= 1), 32'd1);
      for (int c = 0; c < 2; c++) begin
        if (ack_o[c]) begin
          ack_cnt[c]++;
          grant_hist.push_back(c);
          chk("ack_grant", 32'(grant_o), 32'(c));
          if (pend_q[c].size() == 0) begin
            chk("ack_spurious", 32'd1, 32'd0);
          end else begin
            mon_p = pend_q[c].pop_front();
            sb_q.push_back({16'h0, mon_p.target});
            sb_q.push_back({16'h0, mon_p.size});
            for (int k = 0; k < int'(mon_p.size); k++) begin
              sb_q.push_back(mon_p.base + 32'(k));
              src_q[c].push_back(mon_p.base + 32'(k));
            end
          end
        end
      end
      if (tx_o) begin
        if (sb_q.size() == 0) begin
          chk("link_unexpected", data_o, 32'hxxxxxxxx);
        end else begin
          chk("link_flit", data_o, sb_q[0]);
          if (credit_i) begin
            void'(sb_q.pop_front());
            xfer_cnt++;
          end
        end
      end
      if (!busy_o) chk("idle_quiet", {29'd0, tx_o, data_ready_o}, 32'd0);
      for (int c = 0; c < 2; c++) begin
        if (data_ready_o[c]) begin
          rdy_cnt[c]++;
          if (src_q[c].size() == 0) chk("ready_no_data", 32'd1, 32'd0);
          else void'(src_q[c].pop_front());
        end
      end
    end
  end

  initial begin
    vec_t vecs [5];
    int   t3_exp [4];
    int   x0, r0, a0;

    vecs[0] = '{1, 16'h0000, 16'd0, 32'h0000_0000, 1'b0, 2, 0, 3};
    vecs[1] = '{0, 16'hFFFF, 16'd1, 32'h5EED_0000, 1'b0, 3, 1, 4};
    vecs[2] = '{1, 16'h0203, 16'd2, 32'hC0DE_0000, 1'b1, 4, 2, 5};
    vecs[3] = '{0, 16'h1234, 16'd0, 32'h0000_0000, 1'b0, 2, 0, 6};
    vecs[4] = '{1, 16'h0A0B, 16'd5, 32'hBEEF_0010, 1'b1, 7, 5, 7};
    t3_exp[0] = 0; t3_exp[1] = 1; t3_exp[2] = 0; t3_exp[3] = 1;

    rst_i = 1'b1;
    credit_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_pkt", 32'(pkt_count_o), 32'd0);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_ready", 32'(data_ready_o), 32'd0);
    chk("rst_data", data_o, 32'd0);
    rst_i = 1'b0;

    // basic packet on channel 0
    a0 = ack_cnt[0];
    issue(0, 16'h0101, 16'd3, 32'hAAAA_0001);
    wait_idle("t1");
    chk("t1_acks", 32'(ack_cnt[0] - a0), 32'd1);
    chk("t1_pkt", 32'(pkt_count_o), 32'd1);
    chk("t1_busy", 32'(busy_o), 32'd0);

    // credit stalls on the size flit and on the second payload flit
    x0 = xfer_cnt; r0 = rdy_cnt[0];
    issue(0, 16'h0101, 16'd3, 32'hAAAA_0001);
    wait_xfer("t2_hdr", x0 + 1);
    credit_i = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    credit_i = 1'b1;
    wait_xfer("t2_a", x0 + 3);
    credit_i = 1'b0;
    @(posedge clk); #1;
    credit_i = 1'b1;
    wait_idle("t2");
    chk("t2_xfers", 32'(xfer_cnt - x0), 32'd5);
    chk("t2_ready", 32'(rdy_cnt[0] - r0), 32'd3);
    chk("t2_pkt", 32'(pkt_count_o), 32'd2);

    // vector table: channel, header, size, bubbles
    foreach (vecs[i]) begin
      x0 = xfer_cnt; r0 = rdy_cnt[vecs[i].ch];
      bubbles = vecs[i].bub;
      issue(vecs[i].ch, vecs[i].target, vecs[i].size, vecs[i].base);
      wait_idle("vec");
      bubbles = 1'b0;
      chk($sformatf("vec%0d_xfers", i), 32'(xfer_cnt - x0), 32'(vecs[i].exp_xfers));
      chk($sformatf("vec%0d_ready", i), 32'(rdy_cnt[vecs[i].ch] - r0), 32'(vecs[i].exp_rdy));
      chk($sformatf("vec%0d_pkt", i), 32'(pkt_count_o), 32'(vecs[i].exp_pkt));
    end

    // both channels requesting continuously: grants alternate
    grant_hist.delete();
    issue(0, 16'h0001, 16'd1, 32'h1000_0000);
    issue(0, 16'h0002, 16'd1, 32'h1000_0100);
    issue(1, 16'h0101, 16'd1, 32'h2000_0000);
    issue(1, 16'h0102, 16'd1, 32'h2000_0100);
    wait_idle("t3");
    chk("t3_count", 32'(grant_hist.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_hist.size(); i++)
      chk($sformatf("t3_grant%0d", i), 32'(grant_hist[i]), 32'(t3_exp[i]));
    chk("t3_pkt", 32'(pkt_count_o), 32'd11);

    // reset in the middle of a payload
    x0 = xfer_cnt;
    issue(0, 16'h0303, 16'd4, 32'h3000_0000);
    wait_xfer("t5_p0", x0 + 3);
    rst_i = 1'b1;
    @(posedge clk); #1;
    chk("t5_tx", 32'(tx_o), 32'd0);
    chk("t5_busy", 32'(busy_o), 32'd0);
    chk("t5_pkt", 32'(pkt_count_o), 32'd0);
    sb_q.delete();
    src_q[0].delete(); src_q[1].delete();
    pend_q[0].delete(); pend_q[1].delete();
    rst_i = 1'b0;
    grant_hist.delete();
    issue(1, 16'h0404, 16'd1, 32'h4000_0000);
    issue(0, 16'h0505, 16'd1, 32'h5000_0000);
    wait_idle("t5");
    chk("t5_count", 32'(grant_hist.size()), 32'd2);
    if (grant_hist.size() == 2) begin
      chk("t5_first", 32'(grant_hist[0]), 32'd0);
      chk("t5_second", 32'(grant_hist[1]), 32'd1);
    end
    chk("t5_pkt_after", 32'(pkt_count_o), 32'd2);

    // packet counter wrap
    force dut.pkt_count_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut.pkt_count_q;
    @(posedge clk); #1;
    chk("t6_preload", 32'(pkt_count_o), 32'h0000_FFFF);
    issue(1, 16'h0000, 16'd0, 32'h0);
    wait_idle("t6");
    chk("t6_wrap", 32'(pkt_count_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phivers_inject_arb.md
Name: phivers_inject_arb

Overview:
- Multi-channel packet injector/arbiter at a mesh boundary port; the successor to the fixed two-injector (MA/APP) arrangement.
- N_CH host-side sources each request to send one Hermes packet (target address + payload length).
- Round-robin arbitration grants one source per packet; the block emits header flit, size flit and payload flits on a single Hermes credit-based link.
- Sits between injector logic (testbench or host bridge) and the boundary router port.

Parameters:
N_CH, 2, number of source channels (>=1)
FLIT_SIZE, 32, flit width in bits (>=SIZE_W, >=16)
SIZE_W, 16, payload-length field width in flits

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
req_i  in  N_CH  per-channel packet request; held until ack_o
target_i  in  N_CH x 16  per-channel destination router address (XY)
size_i  in  N_CH x SIZE_W  per-channel payload length in flits
ack_o  out  N_CH  one-cycle pulse: request granted, target/size latched
data_i  in  N_CH x FLIT_SIZE  per-channel payload flit
data_valid_i  in  N_CH  payload flit valid
data_ready_o  out  N_CH  payload flit consumed this cycle
tx_o  out  1  Hermes link: flit valid
data_o  out  FLIT_SIZE  Hermes link: flit
credit_i  in  1  Hermes link: receiver can accept (transfer = tx_o && credit_i)
busy_o  out  1  packet in progress (state != IDLE)
grant_o  out  clog2(N_CH) (min 1)  channel currently owning the link
pkt_count_o  out  16  completed packets, wraps

Behaviour:
- Reset (synchronous): state=IDLE, rr pointer=0 (channel 0 highest priority), grant_o=0, ack_o=0, tx_o=0, data_o=0, data_ready_o=0, busy_o=0, pkt_count_o=0. Reset mid-packet abandons the packet; no further flits, and the next cycle shows tx_o=0.
- FSM states: IDLE, HEADER, SIZE, PAYLOAD.
- IDLE:
  - If any req_i is set, grant the first requester scanning from the rr pointer upward, with wrap.
  - Register grant_o; latch target_i/size_i of the winner; pulse ack_o[winner] for that one cycle; go to HEADER.
  - rr pointer = winner+1 mod N_CH.
  - No request: stay IDLE.
- HEADER:
  - tx_o=1, data_o = zero-extended target (bits 15:0).
  - On credit_i go to SIZE; otherwise hold data_o stable.
- SIZE:
  - tx_o=1, data_o = zero-extended latched size.
  - On credit_i: if size==0, go to IDLE and increment pkt_count_o; else load remaining=size and go to PAYLOAD.
- PAYLOAD (combinational passthrough from the granted channel):
  - tx_o = data_valid_i[grant], data_o = data_i[grant].
  - data_ready_o[grant] = data_valid_i[grant] && credit_i; all other data_ready_o are 0.
  - Each transfer decrements remaining.
  - The transfer with remaining==1 ends the packet: go to IDLE and increment pkt_count_o.
  - data_valid_i low inserts bubbles (tx_o=0); no flit is lost or duplicated.
- Latency: request visible in IDLE at cycle t → ack_o at t+1 (registered) → header on the link from t+1 while in HEADER. Minimum packet = 2 + size link cycles plus 1 IDLE cycle between packets.
- req_i, target_i and size_i of non-granted channels are ignored. The granted channel's inputs may change after ack_o.
- tx_o is 0 in IDLE. data_ready_o is 0 outside PAYLOAD.
- pkt_count_o wraps 0xFFFF→0x0000.
- N_CH=1: the arbiter degenerates; grant_o is constant 0.

Test Plan:
1. Ch0 target=0x0101, size=3, payload A,B,C, credit_i=1 → data_o sequence 0x00000101, 0x00000003, A, B, C; ack_o[0] one pulse; pkt_count_o=1; busy_o low afterward.
2. Backpressure: as test 1, with credit_i=0 for 2 cycles during SIZE and again on payload B → data_o held each stall; exactly 5 transfers; data_ready_o[0] asserted exactly 3 times.
3. Both channels hold req_i continuously, size=1 each → grant_o sequence 0,1,0,1; ack_o pulses alternate; pkt_count_o counts 4.
4. Ch1 size=0 target=0x0000 → only 0x00000000 and 0x00000000 transferred; data_ready_o never asserted; back to IDLE; pkt_count_o +1.
5. rst_i asserted after 1 payload flit of a size-4 packet → tx_o=0 next cycle, busy_o=0, pkt_count_o=0; after release, simultaneous requests on ch0/ch1 grant ch0 first.
6. Preload pkt_count_o to 0xFFFF via 65535 size-0 packets (or force) → next completed packet reads 0x0000.
